// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Lets two writeback requesters (for example the ALU result and a memory load)
// share the register file's single write port. One requester is granted per
// cycle using a valid/ready handshake and 1-bit round-robin fairness. The
// granted write is presented to the register file one cycle later on
// registered controls (LD_reg / DR / Load_data).
//
// Optional feature, enabled by defining REGFILE_ARB_CLEAR_EN:
//   a clear sequencer writes 16'h0000 to R0..R7 over eight consecutive cycles
//   without using the global Reset. Without the macro, clr_start is ignored
//   and clr_done / busy are tied low.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   reqN_valid/dr/data    requester N write request (N = 0, 1)
//   reqN_ready            requester N granted this cycle (combinational)
//   clr_start             start the clear sequence (macro builds only)
//   clr_done              one-cycle pulse alongside the DR=7 clear write
//   busy                  clear sequence in progress
//   LD_reg, DR, Load_data registered register-file write port controls
// -----------------------------------------------------------------------------
module regfile_wr_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_valid,
  input  logic [2:0]  req0_dr,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_dr,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        clr_start,
  output logic        clr_done,
  output logic        busy,
  output logic        LD_reg,
  output logic [2:0]  DR,
  output logic [15:0] Load_data
);

  // last_grant_q = 1 means requester 1 won the most recent transfer, so
  // requester 0 takes the next contested cycle.
  logic        last_grant_q, last_grant_d;
  logic        ld_q, ld_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] data_q, data_d;

  // High when the arbiter may hand out a grant this cycle.
  logic        arb_open;
  logic        win0, win1;

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  // A clear request takes priority over any pending writes in the same cycle.
  assign arb_open = (state_q == ARB) && !clr_start;
  assign busy     = (state_q == CLEAR);
  assign clr_done = done_q;
`else
  logic        clr_start_unused;

  assign clr_start_unused = clr_start;
  assign arb_open         = 1'b1;
  assign busy             = 1'b0;
  assign clr_done         = 1'b0;
`endif

  assign win0 = req0_valid && (!req1_valid ||  last_grant_q);
  assign win1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = !Reset && arb_open && win0;
  assign req1_ready = !Reset && arb_open && win1;

  // NOTE: every next-state signal gets a default before any branch so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    last_grant_d = last_grant_q;
    ld_d         = 1'b0;
    dr_d         = dr_q;
    data_d       = data_q;
`ifdef REGFILE_ARB_CLEAR_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
`endif

    if (req0_ready) begin
      ld_d         = 1'b1;
      dr_d         = req0_dr;
      data_d       = req0_data;
      last_grant_d = 1'b0;
    end else if (req1_ready) begin
      ld_d         = 1'b1;
      dr_d         = req1_dr;
      data_d       = req1_data;
      last_grant_d = 1'b1;
    end

`ifdef REGFILE_ARB_CLEAR_EN
    // cnt_q tracks the index being written out on the registered port, so
    // the first clear write (R0) is launched directly from ARB.
    unique case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
          ld_d    = 1'b1;
          dr_d    = 3'd0;
          data_d  = 16'h0000;
        end
      end
      CLEAR: begin
        if (cnt_q == 3'd7) begin
          state_d = ARB;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          ld_d    = 1'b1;
          dr_d    = cnt_q + 3'd1;
          data_d  = 16'h0000;
          done_d  = (cnt_q == 3'd6);
        end
      end
      default: state_d = ARB;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= 1'b1;
      ld_q         <= 1'b0;
      dr_q         <= 3'd0;
      data_q       <= 16'h0000;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q      <= ARB;
      cnt_q        <= 3'd0;
      done_q       <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      ld_q         <= ld_d;
      dr_q         <= dr_d;
      data_q       <= data_d;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
`endif
    end
  end

  assign LD_reg    = ld_q;
  assign DR        = dr_q;
  assign Load_data = data_q;

endmodule
